// File: rtl/counter_wr_arbiter.sv
// Write-port arbiter and interrupt front end for the three-channel counter/timer.
// Three requesters share one registered write port via round-robin arbitration,
// writes to counter channels 0-2 are spaced by a reload guard interval, and the
// asynchronous underflow flags are synchronised into maskable pending bits.
module counter_wr_arbiter #(
    parameter int unsigned GUARD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [5:0]  req_ch,
    input  logic [95:0] req_val,
    output logic [2:0]  req_ready,
    output logic        counter_we,
    output logic [1:0]  counter_ch,
    output logic [31:0] counter_val,
    input  logic        counter0_OUT,
    input  logic        counter1_OUT,
    input  logic        counter2_OUT,
    input  logic [2:0]  irq_en,
    input  logic [2:0]  irq_clr,
    output logic [2:0]  irq_pending,
    output logic        irq
);

    localparam logic [3:0] GUARD_LD = 4'(GUARD);
    localparam logic [1:0] CH_CTRL  = 2'd3;

    // Unpacked per-requester views of the packed request buses
    logic [1:0]  ch_arr  [3];
    logic [31:0] val_arr [3];

    // Guard status per target channel; index 3 (control register) is always free
    logic [3:0]  guard_free;
    logic [2:0]  eligible;

    // Arbitration
    logic [1:0]  last_q, last_d;
    logic [1:0]  cand [3];
    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic        xfer;
    logic [1:0]  xfer_ch;
    logic [31:0] xfer_val;

    // Registered write port
    logic        counter_we_q, counter_we_d;
    logic [1:0]  counter_ch_q, counter_ch_d;
    logic [31:0] counter_val_q, counter_val_d;

    // Underflow synchronisers and pending bits
    logic [2:0]  out_raw;
    logic [2:0]  sync1_q, sync1_d;
    logic [2:0]  sync2_q, sync2_d;
    logic [2:0]  dly_q, dly_d;
    logic [2:0]  rise;
    logic [2:0]  pending_q, pending_d;

    // Round-robin successor in the 0..2 ring
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Per-requester unpacking and eligibility
    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        assign ch_arr[gi]   = req_ch[2*gi +: 2];
        assign val_arr[gi]  = req_val[32*gi +: 32];
        assign eligible[gi] = req_valid[gi] & guard_free[ch_arr[gi]];
    end

    // Per-channel reload guard counters; a new load takes priority over the decrement
    for (genvar gi = 0; gi < 3; gi++) begin : g_guard
        logic [3:0] guard_q, guard_d;
        logic       load;

        assign load = xfer && (xfer_ch == 2'(gi));

        // Next guard value: reload on a transfer to this channel, else count down to zero
        always_comb begin
            guard_d = guard_q;
            if (load) begin
                guard_d = GUARD_LD;
            end else if (guard_q != 4'd0) begin
                guard_d = guard_q - 4'd1;
            end
        end

        // Guard counter register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                guard_q <= 4'd0;
            end else begin
                guard_q <= guard_d;
            end
        end

        assign guard_free[gi] = (guard_q == 4'd0);
    end
    assign guard_free[3] = 1'b1;

    // Round-robin search starting after the last granted requester; nothing is granted in reset
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        cand[0]   = inc3(last_q);
        cand[1]   = inc3(cand[0]);
        cand[2]   = last_q;
        for (int k = 0; k < 3; k++) begin
            if ((grant == 3'b000) && eligible[cand[k]]) begin
                grant[cand[k]] = 1'b1;
                grant_idx      = cand[k];
            end
        end
        if (rst) begin
            grant = 3'b000;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign xfer_ch   = ch_arr[grant_idx];
    assign xfer_val  = val_arr[grant_idx];

    // Pointer and write-port next state; channel/data hold when idle
    always_comb begin
        last_d        = last_q;
        counter_we_d  = 1'b0;
        counter_ch_d  = counter_ch_q;
        counter_val_d = counter_val_q;
        if (xfer) begin
            last_d        = grant_idx;
            counter_we_d  = 1'b1;
            counter_ch_d  = xfer_ch;
            counter_val_d = xfer_val;
        end
    end

    // Arbitration pointer and registered write port; last resets to 2 so requester 0 leads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q        <= 2'd2;
            counter_we_q  <= 1'b0;
            counter_ch_q  <= 2'd0;
            counter_val_q <= 32'd0;
        end else begin
            last_q        <= last_d;
            counter_we_q  <= counter_we_d;
            counter_ch_q  <= counter_ch_d;
            counter_val_q <= counter_val_d;
        end
    end

    assign counter_we  = counter_we_q;
    assign counter_ch  = counter_ch_q;
    assign counter_val = counter_val_q;

    assign out_raw = {counter2_OUT, counter1_OUT, counter0_OUT};
    assign rise    = sync2_q & ~dly_q;

    // Synchroniser chain and pending update; a same-cycle set beats the clear
    always_comb begin
        sync1_d   = out_raw;
        sync2_d   = sync1_q;
        dly_d     = sync2_q;
        pending_d = (pending_q & ~irq_clr) | rise;
    end

    // Two-flop synchroniser, edge-detect flop and pending register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            dly_q     <= 3'b000;
            pending_q <= 3'b000;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dly_q     <= dly_d;
            pending_q <= pending_d;
        end
    end

    assign irq_pending = pending_q;
    assign irq         = |(pending_q & irq_en);

endmodule

// File: tb/tb_counter_wr_arbiter.sv
// Self-checking bench for counter_wr_arbiter: a small arbitration model predicts
// each grant and pushes the expected write into a queue, which is popped and
// compared when the registered write port updates.
module tb_counter_wr_arbiter;

    localparam int GUARD = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [5:0]  req_ch;
    logic [95:0] req_val;
    logic [2:0]  req_ready;
    logic        counter_we;
    logic [1:0]  counter_ch;
    logic [31:0] counter_val;
    logic        counter0_OUT, counter1_OUT, counter2_OUT;
    logic [2:0]  irq_en, irq_clr, irq_pending;
    logic        irq;

    counter_wr_arbiter #(.GUARD(GUARD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ch       (req_ch),
        .req_val      (req_val),
        .req_ready    (req_ready),
        .counter_we   (counter_we),
        .counter_ch   (counter_ch),
        .counter_val  (counter_val),
        .counter0_OUT (counter0_OUT),
        .counter1_OUT (counter1_OUT),
        .counter2_OUT (counter2_OUT),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .irq_pending  (irq_pending),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] val;
    } wr_t;

    wr_t exp_q[$];
    int  m_last;
    int  m_guard[3];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ch_of(input int i);
        logic [5:0] c;
        c = req_ch;
        return c[2*i +: 2];
    endfunction

    function automatic logic [31:0] val_of(input int i);
        logic [95:0] v;
        v = req_val;
        return v[32*i +: 32];
    endfunction

    // Model: first eligible requester in order last+1, last+2, last
    function automatic logic [2:0] model_grant();
        logic [2:0] g;
        int i;
        g = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            i = (m_last + k) % 3;
            if (g == 3'b000 && req_valid[i] &&
                (ch_of(i) == 2'd3 || m_guard[ch_of(i)] == 0)) begin
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic void model_reset();
        m_last = 2;
        for (int c = 0; c < 3; c++) m_guard[c] = 0;
        exp_q.delete();
    endfunction

    // One clock cycle: check grant, advance the model, then check the write port
    task automatic step();
        logic [2:0] g;
        wr_t w;
        int idx;
        #2;
        g = model_grant();
        check("ready", {61'd0, req_ready}, {61'd0, g});
        for (int c = 0; c < 3; c++) if (m_guard[c] != 0) m_guard[c]--;
        if (g != 3'b000) begin
            idx   = g[0] ? 0 : (g[1] ? 1 : 2);
            w.ch  = ch_of(idx);
            w.val = val_of(idx);
            exp_q.push_back(w);
            m_last = idx;
            if (w.ch != 2'd3) m_guard[w.ch] = GUARD;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("we", {63'd0, counter_we}, 64'd1);
            check("ch", {62'd0, counter_ch}, {62'd0, w.ch});
            check("val", {32'd0, counter_val}, {32'd0, w.val});
            $display("write ch=%0d val=%08h", counter_ch, counter_val);
        end else begin
            check("we_idle", {63'd0, counter_we}, 64'd0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 3'b111;
        req_ch       = 6'b11_11_11;
        req_val      = {32'hC2, 32'hB1, 32'hA0};
        counter0_OUT = 1'b0;
        counter1_OUT = 1'b0;
        counter2_OUT = 1'b0;
        irq_en       = 3'b000;
        irq_clr      = 3'b000;
        model_reset();

        // Reset state
        #12;
        check("rst_ready", {61'd0, req_ready}, 64'd0);
        check("rst_we", {63'd0, counter_we}, 64'd0);
        check("rst_ch", {62'd0, counter_ch}, 64'd0);
        check("rst_val", {32'd0, counter_val}, 64'd0);
        check("rst_pend", {61'd0, irq_pending}, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All requesters to control register: grants 0,1,2,0 back to back
        #1; check("rr0", {61'd0, req_ready}, 64'd1); step();
        #1; check("rr1", {61'd0, req_ready}, 64'd2); step();
        #1; check("rr2", {61'd0, req_ready}, 64'd4); step();
        #1; check("rr3", {61'd0, req_ready}, 64'd1); step();

        // Requester 0 writes ch 1, then requester 1 waits out the guard on ch 1
        req_valid = 3'b001;
        req_ch    = {2'd3, 2'd1, 2'd1};
        req_val   = {32'h6, 32'h200, 32'h100};
        #1; check("g_t0", {61'd0, req_ready}, 64'd1); step();
        req_valid = 3'b110;
        #1; check("g_ctrl", {61'd0, req_ready}, 64'd4); step();
        req_valid = 3'b010;
        for (int t = 2; t <= 4; t++) begin
            #1; check("g_wait", {61'd0, req_ready}, 64'd0); step();
        end
        #1; check("g_t5", {61'd0, req_ready}, 64'd2); step();
        req_valid = 3'b000;
        step();

        // Channel 2 underflow: pending after the third edge, irq gated by enable
        irq_en       = 3'b100;
        counter2_OUT = 1'b1;
        step(); check("i_e0", {61'd0, irq_pending}, 64'd0);
        step(); check("i_e1", {61'd0, irq_pending}, 64'd0);
        step(); check("i_e2", {61'd0, irq_pending}, 64'd4);
        check("i_irq", {63'd0, irq}, 64'd1);
        irq_en = 3'b011;
        #1; check("i_mask", {63'd0, irq}, 64'd0);
        counter2_OUT = 1'b0;
        irq_clr      = 3'b100;
        step();
        irq_clr = 3'b000;
        check("i_clr2", {61'd0, irq_pending}, 64'd0);

        // Channel 0: clear coinciding with the set edge loses, later clear wins
        irq_en       = 3'b000;
        counter0_OUT = 1'b1;
        step();
        step();
        irq_clr = 3'b001;
        step();
        irq_clr = 3'b000;
        check("c_set_wins", {61'd0, irq_pending}, 64'd1);
        check("c_irq_off", {63'd0, irq}, 64'd0);
        step();
        check("c_hold", {61'd0, irq_pending}, 64'd1);
        irq_clr = 3'b001;
        step();
        irq_clr = 3'b000;
        check("c_clr", {61'd0, irq_pending}, 64'd0);

        // Reset right after a handshake: write never appears, requester 0 leads afterwards
        req_valid = 3'b001;
        req_ch    = {2'd3, 2'd3, 2'd3};
        req_val   = {32'h77, 32'h66, 32'h55};
        #1; check("r_hs", {61'd0, req_ready}, 64'd1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("r_we", {63'd0, counter_we}, 64'd0);
        check("r_ch", {62'd0, counter_ch}, 64'd0);
        check("r_val", {32'd0, counter_val}, 64'd0);
        check("r_ready", {61'd0, req_ready}, 64'd0);
        check("r_pend", {61'd0, irq_pending}, 64'd0);
        @(posedge clk);
        #1;
        check("r_we2", {63'd0, counter_we}, 64'd0);
        rst       = 1'b0;
        req_valid = 3'b111;
        #1; check("r_first", {61'd0, req_ready}, 64'd1); step();
        req_valid = 3'b000;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_wr_arbiter.md
# counter_wr_arbiter

Write-port arbiter and interrupt front end for the three-channel counter/timer peripheral. It shares the peripheral's single write port (`counter_we`, `counter_ch`, `counter_val`) between three requesters using round-robin arbitration with a valid/ready handshake. It enforces a per-channel reload guard interval so the slower counter clock domains can see each load. It also synchronises the three `counterN_OUT` flags into `clk` and turns their rising edges into maskable, clearable interrupt-pending bits.

## Interface
- `GUARD`, 4: `clk` cycles after a write to channel 0–2 during which further writes to that same channel are ineligible (1..15).
- `clk` in 1: system clock (`clk_CPU`); sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 3: per-requester write request; bit i = requester i.
- `req_ch` in 6: packed target channel; `req_ch[2i+1:2i]` is requester i's channel (3 = control register).
- `req_val` in 96: packed write data; `req_val[32i+31:32i]` is requester i's data.
- `req_ready` out 3: grant; one-hot or zero. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `counter_we` out 1: registered write strobe to the peripheral.
- `counter_ch` out 2: registered channel select.
- `counter_val` out 32: registered write data.
- `counter0_OUT`, `counter1_OUT`, `counter2_OUT` in 1 each: peripheral underflow flags, asynchronous to `clk`.
- `irq_en` in 3: per-channel interrupt enable.
- `irq_clr` in 3: per-channel pending clear, one-cycle pulse.
- `irq_pending` out 3: latched underflow events.
- `irq` out 1: `|(irq_pending & irq_en)`, combinational from registers.

## Operation
- Eligibility: requester i is eligible iff `req_valid[i]` and (`req_ch` i = 3, or guard counter of that channel = 0).
- Arbitration: round-robin pointer `last` (2 bits, values 0..2).
  - Search order is `last+1`, `last+2`, `last` (mod 3).
  - The first eligible requester gets `req_ready`.
  - `req_ready` is combinational from `req_valid`, `req_ch`, `last` and the guard counters.
  - At most one bit is high per cycle.
  - `last` updates to the granted index on transfer only.
- Ineligible valid requesters wait. `req_ready` stays 0 for them and `req_valid`/data must hold until transfer.
- On transfer:
  - Next edge: `counter_we`=1, `counter_ch`=req ch, `counter_val`=req data.
  - If ch≠3, load that channel's guard counter with `GUARD`.
- With no transfer, `counter_we`=0 the next cycle. `counter_ch`/`counter_val` hold their last values.
- Guard counters (3 × 4 bits): decrement by 1 per cycle while nonzero. Loading from a transfer wins over the decrement.
- Writes to ch 3 are never guarded and never blocked by the guards.
- Underflow synchronisers:
  - Each `counterN_OUT` passes through a 2-flop synchroniser, then a third flop for edge detection.
  - A rising edge (delayed=0, synced=1) sets `irq_pending[N]`.
- Pending: `irq_clr[N]` clears bit N. If set and clear coincide in the same cycle, set wins.
- `irq_en` masks `irq` only. Pending bits latch regardless of enable.

## Timing
- Reset values:
  - Outputs: `req_ready`=0 while reset is asserted; `counter_we`=0, `counter_ch`=0, `counter_val`=0, `irq_pending`=0, `irq`=0.
  - Internal state: `last`=2 (so requester 0 has first priority after reset); guard counters = 0; sync flops = 0.
- Write latency: handshake in cycle T gives `counter_we` high in cycle T+1, for exactly one cycle per transfer.
- Throughput: one transfer per cycle.
  - Back-to-back writes to different channels are allowed.
  - Same channel (0–2): next transfer no earlier than T+GUARD+1.
- Interrupt latency: `counterN_OUT` rising, stable before `clk` edge E, gives `irq_pending[N]` high after edge E+2 (3rd edge counting E). `irq` follows in the same cycle.
- An OUT pulse shorter than 2 `clk` periods may be missed; this is acceptable, because counter clocks are divided `clk`.
- Reset asserted mid-operation:
  - Clears everything immediately, including any pending `counter_we`.
  - No transfer completes in a cycle in which `rst` is high.

## Test plan
- After reset, `req_valid`=3'b111, all ch=3 → grants 0,1,2,0 on consecutive cycles; `counter_we` high for 4 cycles with `counter_val` matching each requester's data.
- Requester 0 writes ch 1 val 0x100 at T; requester 1 requests ch 1 from T+1 → `req_ready[1]`=0 through T+4 with GUARD=4, transfer at T+5, `counter_we` at T+6.
- During the ch 1 guard, requester 2 writes ch 3 val 0x6 → granted immediately without waiting.
- Raise `counter2_OUT` before edge E → `irq_pending`=3'b100 after edge E+2; `irq`=1 only if `irq_en[2]`=1.
- `irq_clr[0]` pulsed in the same cycle that channel 0's edge would set the bit → bit stays 1; a later clear with no edge → 0.
- Assert `rst` the cycle after a handshake → `counter_we` never pulses; all outputs 0; the first post-reset grant goes to requester 0.
